// File: rtl/gpio_in_if.sv
// Input GPIO: 2-flop synchroniser, per-pin debounce, sticky rising-edge flags
// with write-1-to-clear, interrupt mask and a registered bus read port.
module gpio_in_if #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned N_IN            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] data_out,
    input  logic [N_IN-1:0] gpio_in,
    output logic            irq
);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_EDGE   = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_RAW    = 2'd3
    } reg_sel_e;

    logic [N_IN-1:0]            sync1_q, sync2_q;
    logic [N_IN-1:0]            stable_q, stable_d;
    logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]            edge_q, edge_d;
    logic [N_IN-1:0]            irq_en_q, irq_en_d;
    logic [XLEN-1:0]            data_out_q, data_out_d;

    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] clr;
    logic [XLEN-1:0] rd_val;
    reg_sel_e        sel;
    logic            unused_ok;

    assign sel       = reg_sel_e'(addr[3:2]);
    assign unused_ok = ^{addr[XLEN-1:4], addr[1:0], data_in};

    // The counter clears on acceptance, so it never exceeds DEBOUNCE_CYCLES-1.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rise     = stable_d & ~stable_q;
        clr      = (en && we && sel == REG_EDGE) ? data_in[N_IN-1:0] : '0;
        edge_d   = (edge_q & ~clr) | rise;
        irq_en_d = (en && we && sel == REG_IRQ_EN) ? data_in[N_IN-1:0] : irq_en_q;

        rd_val = '0;
        unique case (sel)
            REG_DATA:   rd_val[N_IN-1:0] = stable_q;
            REG_EDGE:   rd_val[N_IN-1:0] = edge_q;
            REG_IRQ_EN: rd_val[N_IN-1:0] = irq_en_q;
            REG_RAW:    rd_val[N_IN-1:0] = sync2_q;
        endcase
        data_out_d = (en && !we) ? rd_val : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            irq_en_q   <= '0;
            data_out_q <= '0;
        end else begin
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            irq_en_q   <= irq_en_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_gpio_in_if.sv
// Bench for gpio_in_if: directed scenarios plus random pin/bus traffic against
// a history-based reference model.
module tb_gpio_in_if;

    localparam int N  = 4;
    localparam int DC = 4;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, we;
    logic [XL-1:0] addr, data_in;
    logic [XL-1:0] data_out;
    logic [N-1:0]  gpio_in;
    logic          irq;

    always #5 clk = ~clk;

    gpio_in_if #(
        .XLEN(XL),
        .N_IN(N),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .gpio_in(gpio_in), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pin delay line, history of synchronised samples since
    // reset, and the architectural registers.
    logic [N-1:0]  m_pipe[$];
    logic [N-1:0]  m_hist[$];
    logic [N-1:0]  m_stable, m_edge, m_irqen;
    logic [XL-1:0] m_dout;

    task automatic check(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0]  raw_pre, nstable, clr;
        logic [XL-1:0] rd;
        bit            all_diff;
        if (!rst_n) begin
            @(posedge clk);
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
            m_hist.delete();
            m_stable = '0; m_edge = '0; m_irqen = '0; m_dout = '0;
        end else begin
            raw_pre = m_pipe[0];
            rd = '0;
            case (addr[3:2])
                2'd0: rd[N-1:0] = m_stable;
                2'd1: rd[N-1:0] = m_edge;
                2'd2: rd[N-1:0] = m_irqen;
                default: rd[N-1:0] = raw_pre;
            endcase
            m_hist.push_back(raw_pre);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            nstable = m_stable;
            if (m_hist.size() == DC) begin
                for (int i = 0; i < N; i++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
                    if (all_diff) nstable[i] = ~m_stable[i];
                end
            end
            clr = (en && we && addr[3:2] == 2'd1) ? data_in[N-1:0] : '0;
            @(posedge clk);
            m_edge = (m_edge & ~clr) | (nstable & ~m_stable);
            m_stable = nstable;
            if (en && we && addr[3:2] == 2'd2) m_irqen = data_in[N-1:0];
            if (en && !we) m_dout = rd;
            m_pipe.push_back(gpio_in);
            void'(m_pipe.pop_front());
        end
        #1;
        check("dout_model", data_out, m_dout);
        check("irq_model", {31'b0, irq}, {31'b0, |(m_edge & m_irqen)});
    endtask

    task automatic rd(input logic [XL-1:0] a);
        en = 1'b1; we = 1'b0; addr = a;
        tick();
        en = 1'b0;
    endtask

    task automatic wr(input logic [XL-1:0] a, input logic [XL-1:0] d);
        en = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; data_in = '0; gpio_in = 4'hF;

        // Reset with pins high
        repeat (3) tick();
        check("rst_dout", data_out, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        rd(32'h0);
        check("data_after_rst", data_out, 32'h0);
        repeat (5) tick();
        rd(32'h0);
        check("data_accept_all", data_out, 32'hF);
        rd(32'h4);
        check("edge_accept_all", data_out, 32'hF);
        wr(32'h4, 32'hF);
        gpio_in = 4'h0;
        repeat (10) tick();
        rd(32'h4);
        check("fall_no_edge", data_out, 32'h0);
        rd(32'h0);
        check("data_all_low", data_out, 32'h0);

        // Debounce accept on pin0
        gpio_in = 4'h1;
        tick(); tick();
        rd(32'hC);
        check("raw0_lat", data_out, 32'h1);
        repeat (3) begin
            rd(32'h0);
            check("data0_pending", data_out, 32'h0);
        end
        rd(32'h0);
        check("data0_accept", data_out, 32'h1);
        rd(32'h4);
        check("edge0_set", data_out, 32'h1);
        wr(32'h4, 32'h1);

        // 3-cycle glitch on pin1
        gpio_in = 4'h3;
        repeat (3) rd(32'hC);
        gpio_in = 4'h1;
        rd(32'hC);
        check("raw1_pulse", data_out, 32'h3);
        repeat (8) rd(32'h0);
        check("glitch_data", data_out, 32'h1);
        rd(32'h4);
        check("glitch_edge", data_out, 32'h0);

        // IRQ and W1C
        wr(32'h8, 32'h2);
        gpio_in = 4'h3;
        repeat (8) tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(32'h4, 32'h1);
        check("irq_hold", {31'b0, irq}, 32'h1);
        wr(32'h4, 32'h2);
        check("irq_clr", {31'b0, irq}, 32'h0);
        rd(32'h4);
        check("edge_clr", data_out, 32'h0);

        // Set wins over a simultaneous clear on pin2
        gpio_in = 4'h7;
        repeat (5) tick();
        wr(32'h4, 32'h4);
        rd(32'h4);
        check("set_wins", data_out, 32'h4);
        wr(32'h4, 32'h4);

        // Bus details
        wr(32'h8, 32'hFFFF_FFFF);
        rd(32'h8);
        check("irqen_mask", data_out, 32'hF);
        wr(32'h0, 32'h0);
        rd(32'h0);
        check("data_ro", data_out, 32'h7);
        wr(32'h18, 32'h5);
        rd(32'h8);
        check("alias_wr", data_out, 32'h5);
        rd(32'h18);
        check("alias_rd", data_out, 32'h5);
        wr(32'h8, 32'h0);

        // Reset during debounce of pin3
        gpio_in = 4'hF;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        rd(32'h0);
        check("rst_mid_pending", data_out, 32'h0);
        rd(32'h0);
        check("rst_mid_accept", data_out, 32'hF);
        rd(32'h4);
        check("rst_mid_edge", data_out, 32'hF);

        // Random pin and bus traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) gpio_in[$urandom_range(0, N-1)] ^= 1'b1;
            case ($urandom_range(0, 9))
                0, 1, 2: rd($urandom);
                3:       wr($urandom, $urandom);
                4:       wr({$urandom, 4'h4} & 32'hFFFF_FFF4, $urandom);
                default: tick();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
